divisor_seq: RTL and testbench
==============================

// Module: divisor_seq
// PURPOSE
//  Sequential signed divider for the multicycle MIPS datapath; counterpart of the
//  multiplier (Multiplicador) and the source of the Div_Hi/Div_Lo inputs of the
//  MorDHi/MorDLo muxes. Computes DIV rs,rt: Lo = quotient, Hi = remainder.
//  Started by one control-unit pulse; reports completion or divide-by-zero so the
//  control unit can write Hi/Lo or branch to the exception sequence.
// PARAMETERS
//  WIDTH   32   operand/result width in bits (iteration count = WIDTH)
// PORTS
//  clk         in   1      system clock, all state changes on rising edge
//  reset       in   1      synchronous, active-high reset
//  Div_control in   1      start pulse; sampled only in IDLE
//  RegA_in     in   WIDTH  dividend (two's complement, from register A)
//  RegB_in     in   WIDTH  divisor  (two's complement, from register B)
//  Div_busy    out  1      high while in RUN or DONE
//  Div_done    out  1      one-cycle pulse: Div_Hi/Div_Lo valid and updated
//  Div_zero    out  1      one-cycle pulse: divisor was zero, no result produced
//  Div_Hi      out  WIDTH  remainder (sign of dividend)
//  Div_Lo      out  WIDTH  quotient (truncated toward zero)
// BEHAVIOUR
//  Reset (sync, active-high, any state): state=IDLE; Div_busy=0, Div_done=0,
//   Div_zero=0, Div_Hi=0, Div_Lo=0, iteration counter=0, working regs=0.
//  States: IDLE, RUN, DONE, DZERO.
//  IDLE: Div_control=1 and RegB_in==0 -> DZERO. Div_control=1 and RegB_in!=0 ->
//   latch |A|, |B| (unsigned WIDTH-bit; |0x80000000| = 0x80000000),
//   sign_q = A[W-1]^B[W-1], sign_r = A[W-1]; clear partial remainder; count=0;
//   go RUN. Operands are not sampled again after the start edge.
//  RUN: one restoring step per cycle: R = {R[W-2:0], D[W-1]}, D <<= 1;
//   if R >= |B| then R -= |B|, D[0]=1. Partial remainder is WIDTH+1 bits wide.
//   After WIDTH steps (count == WIDTH-1 on the last) -> DONE.
//  DONE (1 cycle): Div_Lo = sign_q ? -Q : Q; Div_Hi = sign_r ? -R : R (mod 2^W);
//   Div_done=1 in this cycle; Div_Hi/Div_Lo valid from this cycle on; -> IDLE.
//  DZERO (1 cycle): Div_zero=1; Div_Hi/Div_Lo keep previous values; -> IDLE.
//  Latency: start sampled at edge 0 -> Div_done high in cycle WIDTH+1 (33 for 32).
//   Div_zero high in cycle 1.
//  Div_Hi/Div_Lo hold their last value until the next DONE or reset.
//  Div_control while busy (RUN/DONE/DZERO): ignored, no queueing.
//  Div_done and Div_zero never high together; both low in IDLE.
//  Overflow -2^(W-1) / -1: Lo = 0x80000000, Hi = 0, no flag (MIPS: undefined,
//   team decision: wrap result, no exception).
//  Dividend 0: Lo=0, Hi=0. |A| < |B|: Lo=0, Hi=A.
//  Reset mid-RUN: abort immediately, no Div_done pulse, outputs cleared.
// TESTING
//  1. A=7, B=2, start -> Div_done in cycle 33; Lo=0x00000003, Hi=0x00000001.
//  2. A=-7 (0xFFFFFFF9), B=2 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1);
//     A=7, B=-2 -> Lo=0xFFFFFFFD, Hi=0x00000001.
//  3. After test 1, A=5, B=0 -> Div_zero pulse in cycle 1, no Div_done;
//     Hi=1, Lo=3 unchanged; Div_busy low by cycle 2.
//  4. A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0; A=0x80000000, B=1 ->
//     Lo=0x80000000, Hi=0.
//  5. Start A=100, B=7; re-pulse Div_control at cycle 5 with A=1, B=1 ->
//     ignored; result Lo=14, Hi=2 at cycle 33.
//  6. Start A=100, B=7; reset at cycle 10 -> IDLE next edge, Hi=Lo=0, no
//     Div_done; new start A=9, B=3 then gives Lo=3, Hi=0 in cycle 33.

Source files
------------

// File: rtl/divisor_seq.sv
// divisor_seq: restoring signed divider, one quotient bit per clock.
// Div_Lo = quotient truncated toward zero, Div_Hi = remainder with the dividend's sign.
//
// state   | meaning
// S_IDLE  | wait for Div_control; a zero divisor branches to S_DZERO
// S_RUN   | one restoring step per cycle on the magnitudes, WIDTH steps
// S_DONE  | sign-correct and publish Div_Hi/Div_Lo, pulse Div_done
// S_DZERO | pulse Div_zero, previous Div_Hi/Div_Lo are kept
module divisor_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Div_control,
  input  logic [WIDTH-1:0] RegA_in,
  input  logic [WIDTH-1:0] RegB_in,
  output logic             Div_busy,
  output logic             Div_done,
  output logic             Div_zero,
  output logic [WIDTH-1:0] Div_Hi,
  output logic [WIDTH-1:0] Div_Lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE,
    S_DZERO
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_rem;
  logic             r_sign_q;
  logic             r_sign_r;
  logic             r_busy;
  logic             r_done;
  logic             r_zero;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH-1:0] w_rem_sub;
  logic             w_ge;

  // Magnitude of the most negative value wraps to itself, which is the correct unsigned value.
  assign w_abs_a = RegA_in[WIDTH-1] ? -RegA_in : RegA_in;
  assign w_abs_b = RegB_in[WIDTH-1] ? -RegB_in : RegB_in;

  // The shifted remainder needs WIDTH+1 bits for the compare; after subtracting it fits in WIDTH.
  assign w_rem_sh  = {r_rem, r_dvd[WIDTH-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_dvs});
  assign w_rem_sub = w_rem_sh[WIDTH-1:0] - r_dvs;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_zero   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      r_zero <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Div_control) begin
            if (RegB_in == '0) begin
              r_state <= S_DZERO;
            end else begin
              r_dvd    <= w_abs_a;
              r_dvs    <= w_abs_b;
              r_rem    <= '0;
              r_cnt    <= '0;
              r_sign_q <= RegA_in[WIDTH-1] ^ RegB_in[WIDTH-1];
              r_sign_r <= RegA_in[WIDTH-1];
              r_busy   <= 1'b1;
              r_state  <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_rem <= w_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0];
          r_dvd <= {r_dvd[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt + CNT_ONE;
          if (r_cnt == CNT_LAST) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_lo    <= r_sign_q ? -r_dvd : r_dvd;
          r_hi    <= r_sign_r ? -r_rem : r_rem;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        S_DZERO: begin
          r_zero  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Div_busy = r_busy;
  assign Div_done = r_done;
  assign Div_zero = r_zero;
  assign Div_Hi   = r_hi;
  assign Div_Lo   = r_lo;

endmodule

// File: tb/tb_divisor_seq.sv
// Testbench for divisor_seq: directed cases plus random operands against a
// plain-arithmetic signed division model.
module tb_divisor_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         Div_control = 1'b0;
  logic [W-1:0] RegA_in = '0;
  logic [W-1:0] RegB_in = '0;
  logic         Div_busy;
  logic         Div_done;
  logic         Div_zero;
  logic [W-1:0] Div_Hi;
  logic [W-1:0] Div_Lo;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] ref_hi = '0;
  logic [W-1:0] ref_lo = '0;

  always #5 clk = ~clk;

  divisor_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .Div_control(Div_control),
    .RegA_in    (RegA_in),
    .RegB_in    (RegB_in),
    .Div_busy   (Div_busy),
    .Div_done   (Div_done),
    .Div_zero   (Div_zero),
    .Div_Hi     (Div_Hi),
    .Div_Lo     (Div_Lo)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Signed division on 64-bit integers: truncation toward zero, remainder takes the dividend sign.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r);
    longint sa, sb, lq, lr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    lq = sa / sb;
    lr = sa % sb;
    q = lq[W-1:0];
    r = lr[W-1:0];
  endtask

  // Start at edge 0, then watch cycles 1..40. pulse_at/reset_at inject a
  // Div_control pulse or a reset sampled at that edge (0 = none).
  task automatic do_div(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int pulse_at, input int reset_at);
    logic [W-1:0] eq, er, hi_at_done, lo_at_done;
    int done_cyc, zero_cyc, ndone, nzero, nboth;
    bit aborted;
    done_cyc = -1; zero_cyc = -1; ndone = 0; nzero = 0; nboth = 0; aborted = 0;
    hi_at_done = '0; lo_at_done = '0;
    @(negedge clk);
    Div_control = 1'b1; RegA_in = a; RegB_in = b;
    @(posedge clk); #1;
    Div_control = 1'b0; RegA_in = $urandom; RegB_in = $urandom;
    for (int c = 1; c <= 40; c++) begin
      if (c == pulse_at) begin
        Div_control = 1'b1; RegA_in = 32'd1; RegB_in = 32'd1;
      end else begin
        Div_control = 1'b0;
      end
      reset = (c == reset_at);
      @(posedge clk); #1;
      if (Div_done) begin ndone++; if (done_cyc < 0) begin done_cyc = c; hi_at_done = Div_Hi; lo_at_done = Div_Lo; end end
      if (Div_zero) begin nzero++; if (zero_cyc < 0) zero_cyc = c; end
      if (Div_done && Div_zero) nboth++;
      if (c == 1 && reset_at != 1) chk({name, ":busy_c1"}, {31'd0, Div_busy}, {31'd0, b != '0});
      if (c == 2 && b == '0) chk({name, ":busy_c2"}, {31'd0, Div_busy}, 32'd0);
      if (c == reset_at) begin
        aborted = 1;
        chk({name, ":rst_hi"}, Div_Hi, '0);
        chk({name, ":rst_lo"}, Div_Lo, '0);
        chk({name, ":rst_busy"}, {31'd0, Div_busy}, 32'd0);
        ref_hi = '0; ref_lo = '0;
      end
    end
    reset = 1'b0;
    chk({name, ":both_flags"}, nboth, 32'd0);
    if (aborted) begin
      chk({name, ":ndone_abort"}, ndone, 32'd0);
      chk({name, ":nzero_abort"}, nzero, 32'd0);
    end else if (b == '0) begin
      chk({name, ":zero_cyc"}, zero_cyc, 32'd1);
      chk({name, ":nzero"}, nzero, 32'd1);
      chk({name, ":ndone"}, ndone, 32'd0);
    end else begin
      model(a, b, eq, er);
      chk({name, ":done_cyc"}, done_cyc, W + 1);
      chk({name, ":ndone"}, ndone, 32'd1);
      chk({name, ":nzero"}, nzero, 32'd0);
      chk({name, ":lo_at_done"}, lo_at_done, eq);
      chk({name, ":hi_at_done"}, hi_at_done, er);
      ref_lo = eq; ref_hi = er;
    end
    chk({name, ":lo_held"}, Div_Lo, ref_lo);
    chk({name, ":hi_held"}, Div_Hi, ref_hi);
    chk({name, ":busy_end"}, {31'd0, Div_busy}, 32'd0);
  endtask

  initial begin
    logic [W-1:0] a, b;
    int mode;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset:busy", {31'd0, Div_busy}, 32'd0);
    chk("reset:done", {31'd0, Div_done}, 32'd0);
    chk("reset:zero", {31'd0, Div_zero}, 32'd0);
    chk("reset:hi", Div_Hi, '0);
    chk("reset:lo", Div_Lo, '0);
    reset = 1'b0;

    do_div("t1_7div2", 32'd7, 32'd2, 0, 0);
    chk("t1:lo_const", Div_Lo, 32'h0000_0003);
    chk("t1:hi_const", Div_Hi, 32'h0000_0001);
    do_div("t3_div0", 32'd5, 32'd0, 0, 0);
    chk("t3:lo_kept", Div_Lo, 32'h0000_0003);
    chk("t3:hi_kept", Div_Hi, 32'h0000_0001);
    do_div("t2_neg7div2", 32'hFFFF_FFF9, 32'd2, 0, 0);
    chk("t2a:lo_const", Div_Lo, 32'hFFFF_FFFD);
    chk("t2a:hi_const", Div_Hi, 32'hFFFF_FFFF);
    do_div("t2_7divneg2", 32'd7, 32'hFFFF_FFFE, 0, 0);
    chk("t2b:lo_const", Div_Lo, 32'hFFFF_FFFD);
    chk("t2b:hi_const", Div_Hi, 32'h0000_0001);
    do_div("t4_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    chk("t4a:lo_const", Div_Lo, 32'h8000_0000);
    chk("t4a:hi_const", Div_Hi, 32'h0000_0000);
    do_div("t4_min_div1", 32'h8000_0000, 32'd1, 0, 0);
    chk("t4b:lo_const", Div_Lo, 32'h8000_0000);
    chk("t4b:hi_const", Div_Hi, 32'h0000_0000);
    do_div("dividend0", 32'd0, 32'hFFFF_FFF3, 0, 0);
    do_div("a_lt_b", 32'hFFFF_FFFB, 32'd9, 0, 0);
    do_div("t5_repulse", 32'd100, 32'd7, 5, 0);
    chk("t5:lo_const", Div_Lo, 32'd14);
    chk("t5:hi_const", Div_Hi, 32'd2);
    do_div("t6_reset", 32'd100, 32'd7, 0, 10);
    do_div("t6_after", 32'd9, 32'd3, 0, 0);
    chk("t6:lo_const", Div_Lo, 32'd3);
    chk("t6:hi_const", Div_Hi, 32'd0);

    for (int i = 0; i < 18; i++) begin
      mode = $urandom_range(0, 3);
      a = $urandom;
      b = $urandom;
      if (mode == 1) b = 32'($urandom_range(0, 40)) - 32'd20;
      if (mode == 2) b = '0;
      if (mode == 3) a = 32'($urandom_range(0, 200)) - 32'd100;
      do_div($sformatf("rnd%0d", i), a, b, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
